// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the IF/MEM RAM arbiter: FSM state encoding and
// default values for the starvation guard and the RAM watchdog.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } arb_state_t;

    // Consecutive MEM grants allowed while IF is waiting.
    localparam int DEF_STARVE_MAX = 3;
    // Wait cycles without ramAck before a transaction is aborted (8-bit counter).
    localparam int DEF_TIMEOUT    = 255;
    localparam int WD_W           = 8;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arbiter_watchdog
// Loadable 8-bit wait counter for the RAM handshake.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_clr      : clear counter to 0 (highest priority)
//   i_load     : load i_load_val
//   i_load_val : value loaded by i_load
//   i_en       : count one wait cycle
//   o_expire   : counter holds TIMEOUT-1, i.e. the current wait cycle is the
//                TIMEOUT-th one and the owner should abort at the next edge
// -----------------------------------------------------------------------------
module mem_arbiter_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_load,
    input  logic [WD_W-1:0] i_load_val,
    input  logic            i_en,
    output logic            o_expire
);

    logic [WD_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + WD_W'(1);
        end
    end

    // Not gated by i_en so the owner's next-state logic has no loop through it.
    assign o_expire = (r_cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between the IF stage (fetch) and the MEM stage
// (load/store). MEM normally wins; a starvation guard forces an IF grant after
// STARVE_MAX MEM grants made while IF was waiting. A watchdog aborts an access
// that sees no ramAck for TIMEOUT cycles and sets a sticky bus error.
//   i_clk/i_rst_n                     : clock, asynchronous active-low reset
//   i_if_req/i_if_addr                : fetch request, held until o_if_ready
//   o_if_rdata/o_if_ready/o_if_stall  : fetched word, 1-cycle done, stall
//   i_mem_req/i_mem_we/i_mem_addr/i_mem_wdata : load/store request
//   o_mem_rdata/o_mem_ready/o_mem_stall       : load data, 1-cycle done, stall
//   o_ram_req/o_ram_we/o_ram_addr/o_ram_wdata : RAM strobe (held until ack)
//   i_ram_rdata/i_ram_ack             : RAM read data / completion
//   o_bus_err                         : sticky watchdog-abort flag
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ready,
    output logic              o_if_stall,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_mem_ready,
    output logic              o_mem_stall,
    output logic              o_ram_req,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    input  logic              i_ram_ack,
    output logic              o_bus_err
);

    localparam int              SC_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    arb_state_t        r_state, w_state_next;
    logic [SC_W-1:0]   r_starve_cnt, w_starve_next;
    logic              r_ram_req, w_ram_req_next;
    logic              r_ram_we, w_ram_we_next;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_next;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_next;
    logic              r_if_ready, w_if_ready_next;
    logic              r_mem_ready, w_mem_ready_next;
    logic              r_bus_err, w_bus_err_next;

    logic w_if_req_eff, w_mem_req_eff, w_if_wins;
    logic w_grant, w_done, w_wd_en, w_wd_expire;

    // A requester whose ready is high this cycle has just been served; its
    // still-high req belongs to the finished transaction and must not re-grant.
    assign w_if_req_eff  = i_if_req  & ~r_if_ready;
    assign w_mem_req_eff = i_mem_req & ~r_mem_ready;
    assign w_if_wins     = w_if_req_eff & (~w_mem_req_eff | (r_starve_cnt == SC_MAX));

    always_comb begin
        w_state_next     = r_state;
        w_starve_next    = r_starve_cnt;
        w_ram_req_next   = r_ram_req;
        w_ram_we_next    = r_ram_we;
        w_ram_addr_next  = r_ram_addr;
        w_ram_wdata_next = r_ram_wdata;
        w_if_rdata_next  = r_if_rdata;
        w_mem_rdata_next = r_mem_rdata;
        w_if_ready_next  = 1'b0;
        w_mem_ready_next = 1'b0;
        w_bus_err_next   = r_bus_err;
        w_grant          = 1'b0;
        w_done           = 1'b0;
        w_wd_en          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_if_wins) begin
                    w_grant         = 1'b1;
                    w_ram_req_next  = 1'b1;
                    w_ram_we_next   = 1'b0;
                    w_ram_addr_next = i_if_addr;
                    w_starve_next   = '0;
                    w_state_next    = IF_BUSY;
                end else if (w_mem_req_eff) begin
                    w_grant          = 1'b1;
                    w_ram_req_next   = 1'b1;
                    w_ram_we_next    = i_mem_we;
                    w_ram_addr_next  = i_mem_addr;
                    w_ram_wdata_next = i_mem_wdata;
                    if (w_if_req_eff && (r_starve_cnt != SC_MAX)) begin
                        w_starve_next = r_starve_cnt + SC_W'(1);
                    end
                    w_state_next = MEM_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (i_ram_ack) begin
                    w_done         = 1'b1;
                    w_ram_req_next = 1'b0;
                    w_state_next   = IDLE;
                    if (r_state == IF_BUSY) begin
                        w_if_ready_next = 1'b1;
                        w_if_rdata_next = i_ram_rdata;
                    end else begin
                        w_mem_ready_next = 1'b1;
                        if (!r_ram_we) begin
                            w_mem_rdata_next = i_ram_rdata;
                        end
                    end
                end else begin
                    w_wd_en = 1'b1;
                    if (w_wd_expire) begin
                        w_done         = 1'b1;
                        w_ram_req_next = 1'b0;
                        w_bus_err_next = 1'b1;
                        w_state_next   = IDLE;
                        if (r_state == IF_BUSY) begin
                            w_if_ready_next = 1'b1;
                            w_if_rdata_next = '0;
                        end else begin
                            w_mem_ready_next = 1'b1;
                            w_mem_rdata_next = '0;
                        end
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_ram_req    <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_if_ready   <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_ram_req    <= w_ram_req_next;
            r_ram_we     <= w_ram_we_next;
            r_ram_addr   <= w_ram_addr_next;
            r_ram_wdata  <= w_ram_wdata_next;
            r_if_rdata   <= w_if_rdata_next;
            r_mem_rdata  <= w_mem_rdata_next;
            r_if_ready   <= w_if_ready_next;
            r_mem_ready  <= w_mem_ready_next;
            r_bus_err    <= w_bus_err_next;
        end
    end

    // Counts wait cycles of the current access; restarts on each grant.
    mem_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_done),
        .i_load     (w_grant),
        .i_load_val ('0),
        .i_en       (w_wd_en),
        .o_expire   (w_wd_expire)
    );

    assign o_ram_req   = r_ram_req;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_ready  = r_if_ready;
    assign o_mem_rdata = r_mem_rdata;
    assign o_mem_ready = r_mem_ready;
    assign o_bus_err   = r_bus_err;
    assign o_if_stall  = i_if_req  & ~r_if_ready;
    assign o_mem_stall = i_mem_req & ~r_mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. A small RAM responder acks after a
// programmable number of wait cycles (or never); expected read data is queued
// per requester when a request is driven and compared on each ready pulse.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        bus_err;

    mem_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_ready  (if_ready),
        .o_if_stall  (if_stall),
        .i_mem_req   (mem_req),
        .i_mem_we    (mem_we),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .o_mem_rdata (mem_rdata),
        .o_mem_ready (mem_ready),
        .o_mem_stall (mem_stall),
        .o_ram_req   (ram_req),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .i_ram_ack   (ram_ack),
        .o_bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM responder ----------------
    int ram_wait;        // wait cycles before ack; negative = never ack
    int ram_busy_cnt;
    bit ram_ack_force;   // ack regardless of ram_req

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h2002000A;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (ram_req && !ram_ack) ram_busy_cnt <= ram_busy_cnt + 1;
        else                     ram_busy_cnt <= 0;
    end

    assign ram_ack   = ram_ack_force || (ram_req && (ram_wait >= 0) && (ram_busy_cnt == ram_wait));
    assign ram_rdata = ram_ack ? ram_word(ram_addr) : 32'hBAD0BAD0;

    // ---------------- scoreboard / bookkeeping ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;

    logic [31:0] if_exp_q[$];
    logic [31:0] mem_exp_q[$];
    grant_t      grant_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    int          if_done_cyc;
    int          mem_done_cyc;
    int          ram_req_cycles;
    logic        prev_ram_req = 1'b0;
    bit          auto_drop = 1'b1;
    logic [31:0] last_mem_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic start_scn();
        cyc            = 0;
        ram_req_cycles = 0;
        if_done_cyc    = -1;
        mem_done_cyc   = -1;
        grant_q.delete();
    endtask

    // Advance one cycle, sample #1 after the edge, score any ready pulse.
    task automatic step();
        logic [31:0] exp;
        grant_t      g;
        @(posedge clk);
        #1;
        cyc++;
        if (ram_req) ram_req_cycles++;
        if (ram_req && !prev_ram_req) begin
            g.addr  = ram_addr;
            g.we    = ram_we;
            g.wdata = ram_wdata;
            grant_q.push_back(g);
        end
        prev_ram_req = ram_req;
        check_bit("if_stall", if_stall, if_req & ~if_ready);
        check_bit("mem_stall", mem_stall, mem_req & ~mem_ready);
        if (if_ready) begin
            n_checks++;
            assert (if_exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL if_ready_unexpected observed=1 expected=0 cyc=%0d", cyc);
            end
            if (if_exp_q.size() != 0) begin
                exp = if_exp_q.pop_front();
                check("if_rdata", if_rdata, exp);
            end
            $display("txn IF  done cyc=%0d rdata=0x%08h bus_err=%b", cyc, if_rdata, bus_err);
            if_done_cyc = cyc;
            if (auto_drop) if_req = 1'b0;
        end
        if (mem_ready) begin
            n_checks++;
            assert (mem_exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL mem_ready_unexpected observed=1 expected=0 cyc=%0d", cyc);
            end
            if (mem_exp_q.size() != 0) begin
                exp = mem_exp_q.pop_front();
                check("mem_rdata", mem_rdata, exp);
            end
            $display("txn MEM done cyc=%0d rdata=0x%08h bus_err=%b", cyc, mem_rdata, bus_err);
            mem_done_cyc = cyc;
            if (auto_drop) mem_req = 1'b0;
        end
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int i = 0;
        while (((if_exp_q.size() != 0) || (mem_exp_q.size() != 0)) && (i < budget)) begin
            step();
            i++;
        end
        check({tag, "_pending"}, if_exp_q.size() + mem_exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    initial begin
        bit if_gap;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_wait = 0; ram_ack_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check_bit("rst_ram_req", ram_req, 1'b0);
        check_bit("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check_bit("rst_if_ready", if_ready, 1'b0);
        check_bit("rst_mem_ready", mem_ready, 1'b0);
        check_bit("rst_bus_err", bus_err, 1'b0);
        rst_n = 1'b1;
        step();

        // 1: single zero-wait fetch
        start_scn();
        if_addr = 32'h40; if_req = 1'b1; if_exp_q.push_back(32'h2002000A);
        run_until_done(20, "s1");
        check("s1_if_latency", if_done_cyc, 2);
        check("s1_ram_req_cycles", ram_req_cycles, 1);
        check("s1_grant_addr", grant_q[0].addr, 32'h40);
        check_bit("s1_grant_we", grant_q[0].we, 1'b0);
        repeat (2) step();

        // 2: simultaneous IF and MEM load, ack in third cycle of ramReq
        start_scn();
        ram_wait = 2;
        mem_addr = 32'h100; mem_we = 1'b0; mem_req = 1'b1;
        if_addr = 32'h40; if_req = 1'b1;
        mem_exp_q.push_back(ram_word(32'h100));
        if_exp_q.push_back(32'h2002000A);
        last_mem_data = ram_word(32'h100);
        run_until_done(40, "s2");
        check("s2_mem_latency", mem_done_cyc, 4);
        check("s2_if_latency", if_done_cyc, 8);
        check("s2_grant_count", grant_q.size(), 2);
        check("s2_first_grant", grant_q[0].addr, 32'h100);
        check("s2_second_grant", grant_q[1].addr, 32'h40);
        repeat (2) step();

        // 3: store, one wait cycle
        start_scn();
        ram_wait = 1;
        mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hCAFE; mem_req = 1'b1;
        mem_exp_q.push_back(last_mem_data);
        run_until_done(20, "s3");
        mem_we = 1'b0;
        check("s3_mem_latency", mem_done_cyc, 3);
        check("s3_grant_addr", grant_q[0].addr, 32'h200);
        check_bit("s3_grant_we", grant_q[0].we, 1'b1);
        check("s3_grant_wdata", grant_q[0].wdata, 32'hCAFE);
        repeat (2) step();

        // 4: starvation guard; IF withdraws during each memReady cycle
        start_scn();
        ram_wait = 0; auto_drop = 1'b0; if_gap = 1'b0;
        mem_addr = 32'h300; if_addr = 32'h80; mem_req = 1'b1; if_req = 1'b1;
        repeat (3) mem_exp_q.push_back(ram_word(32'h300));
        if_exp_q.push_back(ram_word(32'h80));
        for (int i = 0; (i < 60) && ((if_exp_q.size() != 0) || (mem_exp_q.size() != 0)); i++) begin
            step();
            if (mem_ready) begin
                if_req = 1'b0; if_gap = 1'b1;
            end else if (if_gap) begin
                if_req = 1'b1; if_gap = 1'b0;
            end
            if (if_ready) begin
                mem_req = 1'b0; if_req = 1'b0;
            end
        end
        auto_drop = 1'b1;
        check("s4_pending", if_exp_q.size() + mem_exp_q.size(), 0);
        check("s4_if_done_cyc", if_done_cyc, 11);
        check("s4_grant_count", grant_q.size(), 4);
        for (int i = 0; i < 3; i++) check("s4_mem_grant_addr", grant_q[i].addr, 32'h300);
        check("s4_if_grant_addr", grant_q[3].addr, 32'h80);
        check("s4_starve_cleared", 32'(dut.r_starve_cnt), 32'd0);
        repeat (2) step();

        // 5: ramAck while idle is ignored
        start_scn();
        ram_ack_force = 1'b1;
        repeat (3) begin
            step();
            check_bit("s5_if_ready_idle_ack", if_ready, 1'b0);
            check_bit("s5_mem_ready_idle_ack", mem_ready, 1'b0);
        end
        ram_ack_force = 1'b0;
        check("s5_ram_req_cycles", ram_req_cycles, 0);

        // 6: watchdog abort
        start_scn();
        ram_wait = -1;
        if_addr = 32'h44; if_req = 1'b1; if_exp_q.push_back(32'h0);
        run_until_done(300, "s6");
        check("s6_ram_req_cycles", ram_req_cycles, 255);
        check("s6_if_done_cyc", if_done_cyc, 256);
        check_bit("s6_bus_err", bus_err, 1'b1);
        repeat (3) step();
        start_scn();
        ram_wait = 0;
        mem_addr = 32'h104; mem_req = 1'b1; mem_exp_q.push_back(ram_word(32'h104));
        run_until_done(20, "s6b");
        check_bit("s6_bus_err_sticky", bus_err, 1'b1);
        repeat (2) step();

        // 7: reset during a pending access
        start_scn();
        ram_wait = 5;
        if_addr = 32'h40; if_req = 1'b1; if_exp_q.push_back(32'h2002000A);
        step();
        step();
        check_bit("s7_ram_req_before_reset", ram_req, 1'b1);
        #2;
        rst_n = 1'b0; if_req = 1'b0;
        #1;
        if_exp_q.delete();
        check_bit("s7_ram_req", ram_req, 1'b0);
        check_bit("s7_bus_err", bus_err, 1'b0);
        check("s7_if_rdata", if_rdata, 32'h0);
        check("s7_mem_rdata", mem_rdata, 32'h0);
        check("s7_ram_addr", ram_addr, 32'h0);
        check_bit("s7_if_ready", if_ready, 1'b0);
        check_bit("s7_if_stall", if_stall, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_scn();
        repeat (4) step();
        check("s7_no_access_after_reset", ram_req_cycles, 0);
        check("s7_no_if_ready_after_reset", if_done_cyc, -1);
        start_scn();
        ram_wait = 0;
        if_addr = 32'h40; if_req = 1'b1; if_exp_q.push_back(32'h2002000A);
        run_until_done(20, "s7b");
        check("s7_if_latency", if_done_cyc, 2);
        check("s7_ram_req_cycles", ram_req_cycles, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
